dma_word_copier: RTL and testbench
==================================

Name: dma_word_copier

Overview:
- Bus initiator that copies a block of 32-bit words through the memory data port (a2/wd/we2/rd2) of the unified memory, on behalf of a host that starts it.
- Arbitrates for the port with a req/gnt handshake against the CPU, then performs read–wait–write per word.
- Refuses destination ranges touching the MMIO window 0xC000_0000–0xC000_0007 (switches/LEDs) so memory-mapped side effects are never triggered by a copy. MMIO sources (e.g. switch snapshots) are allowed.

Parameters:
- RD_LAT, 1, cycles from address on a2 to valid data on rd2 (≥1)
- CNT_W, 16, width of word-count input

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin transfer; sampled only in IDLE
- src  in  32  source byte address, word aligned
- dst  in  32  destination byte address, word aligned
- count  in  CNT_W  number of words
- abort  in  1  stop at next word boundary
- gnt  in  1  port granted by arbiter
- rd2  in  32  read data from memory port
- req  out  1  port request
- a2  out  32  port byte address
- wd  out  32  port write data
- we2  out  1  port write enable
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = rejected or aborted

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; req, a2, wd, we2, busy, done and err all 0; internal pointers and counter cleared. Reset mid-write drops we2 immediately, and the word is not guaranteed written.
- States: IDLE, REQ, RD, WAIT, WR, HOLD, DONE. busy=1 in REQ/RD/WAIT/WR/HOLD. req=1 in REQ through HOLD.
- IDLE with start=1: latch src, dst, count.
  - If src[1:0]!=0, dst[1:0]!=0, the dst range wraps (dst+4*(count-1) mod 2^32 < dst), or any dst word address lies in 0xC000_0000–0xC000_0007: go to DONE with err=1. No bus activity.
  - Else if count=0: go to DONE with err=0.
  - Else: go to REQ.
- REQ: hold req=1. On gnt=1, go to RD. If abort=1, go to DONE with err=1.
- RD (1 cycle): a2=src_ptr, we2=0. Go to WAIT.
- WAIT (RD_LAT cycles): a2 held, we2=0. Capture rd2 at the end of the last WAIT cycle. Go to WR.
- WR (1 cycle): a2=dst_ptr, wd=captured word, we2=1. Then src_ptr+=4, dst_ptr+=4 (mod 2^32), remaining-=1.
  - If remaining=0: go to DONE, err=0.
  - Else if abort seen since the last word boundary: go to DONE, err=1.
  - Else if gnt=1: go to RD.
  - Else: go to HOLD.
- HOLD: req=1, we2=0. Wait for gnt=1, then go to RD. abort=1 in HOLD goes to DONE with err=1.
- gnt is only checked at word boundaries (REQ/WR/HOLD). The arbiter must not revoke gnt inside RD–WAIT–WR; a word is never torn.
- DONE (1 cycle): done=1, err as determined, req=0, busy=0, we2=0. Then go to IDLE.
- start while busy, and abort in IDLE, are ignored.
- Timing with gnt held 1 (start sampled at cycle 0): done is asserted at cycle 2+count*(2+RD_LAT).
- we2 is high only in WR. When we2=0, wd holds its last value.

Test Plan:
1. Normal copy: RD_LAT=1, gnt=1, mem[0x00..0x0C]={0x11111111,0x22222222,0x33333333,0x44444444}, start src=0x00 dst=0x80 count=4 -> four single-cycle we2 pulses at 0x80/84/88/8C with matching data; done=1, err=0 at cycle 14.
2. Zero count and misalignment: count=0 -> done at cycle 1, err=0, req never 1; src=0x02 count=1 -> done at cycle 1, err=1, no we2.
3. MMIO guard: dst=0xBFFF_FFFC count=2 -> err=1, no writes. Same transfer with count=1 -> writes 0xBFFF_FFFC, err=0.
4. Arbitration: gnt=0 for 3 cycles after start, then gnt dropped after the first WR for 2 cycles -> req stays 1, no RD/WR issued while gnt=0 at a boundary, all data correct, done delayed by 5 cycles versus case 1.
5. Abort: abort pulsed during WAIT of word 2 of 4 -> word 2 written, exactly 2 writes, done with err=1.
6. Reset mid-transfer: reset=0 asynchronously during WR of word 3, then start again with RD_LAT=2 and count=2 -> all outputs 0 immediately on reset; new transfer done at cycle 10 with correct data.

Source files
------------

// File: rtl/dma_word_copier.sv
// dma_word_copier: copies count 32-bit words from src to dst over the shared memory port.
// Ports: clk/reset (async active-low); start/src/dst/count launch a copy, abort stops at a word boundary;
// req/gnt arbitrate the port; a2/wd/we2/rd2 drive the memory port; busy, and done/err report completion.
module dma_word_copier #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  input  logic             gnt,
  input  logic [31:0]      rd2,
  output logic             req,
  output logic [31:0]      a2,
  output logic [31:0]      wd,
  output logic             we2,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WAIT, WR, HOLD, DONE} state_t;
  localparam int LW = $clog2(RD_LAT + 1);
  state_t           state;
  logic [31:0]      src_ptr, dst_ptr, last;
  logic [CNT_W-1:0] rem;
  logic [LW-1:0]    wcnt;
  logic             abort_seen, bad;
  // last destination word; a wrap shows up as last < dst, MMIO hit as overlap with 0xC0000000..0xC0000004
  assign last = dst + ((32'(count) - 32'd1) << 2);
  assign bad  = (|src[1:0]) | (|dst[1:0]) |
                ((count != '0) & ((last < dst) | ((dst <= 32'hC000_0004) & (last >= 32'hC000_0000))));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      req        <= 1'b0;
      a2         <= '0;
      wd         <= '0;
      we2        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      rem        <= '0;
      wcnt       <= '0;
      abort_seen <= 1'b0;
    end else begin
      we2  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src_ptr <= src;
          dst_ptr <= dst;
          rem     <= count;
          if (bad || count == '0) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= bad;
          end else begin
            state <= REQ;
            req   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ, HOLD: if (abort) begin
          state <= DONE;
          done  <= 1'b1;
          err   <= 1'b1;
          req   <= 1'b0;
          busy  <= 1'b0;
        end else if (gnt) begin
          state      <= RD;
          a2         <= src_ptr;
          abort_seen <= 1'b0;
        end
        RD: begin
          state      <= WAIT;
          wcnt       <= '0;
          abort_seen <= abort_seen | abort;
        end
        WAIT: begin
          abort_seen <= abort_seen | abort;
          wcnt       <= wcnt + LW'(1);
          if (wcnt == LW'(RD_LAT - 1)) begin
            state <= WR;
            a2    <= dst_ptr;
            wd    <= rd2;
            we2   <= 1'b1;
          end
        end
        WR: begin
          src_ptr <= src_ptr + 32'd4;
          dst_ptr <= dst_ptr + 32'd4;
          rem     <= rem - CNT_W'(1);
          if (rem == CNT_W'(1) || abort_seen || abort) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= rem != CNT_W'(1);
            req   <= 1'b0;
            busy  <= 1'b0;
          end else if (gnt) begin
            state <= RD;
            a2    <= src_ptr + 32'd4;
          end else state <= HOLD;
        end
        DONE: begin
          state <= IDLE;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dma_word_copier.sv
// tb_dma_word_copier: directed checks of dma_word_copier at RD_LAT=1 and RD_LAT=2.
module tb_dma_word_copier;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, start2 = 1'b0, abort = 1'b0, gnt = 1'b1;
  logic [31:0] src = '0, dst = '0;
  logic [15:0] count = '0;
  logic [31:0] rd2_1 = '0, rd2_2 = '0, p2 = '0;
  logic        req1, we2_1, busy1, done1, err1, req2, we2_2, busy2, done2, err2;
  logic [31:0] a2_1, wd_1, a2_2, wd_2;
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] mem2 [logic [31:0]];
  logic [31:0] wa1 [$], wv1 [$], wa2 [$], wv2 [$];
  int          reqc1 = 0, total = 0, bad = 0;

  always #5 clk = ~clk;

  dma_word_copier #(.RD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .count(count),
    .abort(abort), .gnt(gnt), .rd2(rd2_1), .req(req1), .a2(a2_1), .wd(wd_1),
    .we2(we2_1), .busy(busy1), .done(done1), .err(err1));

  dma_word_copier #(.RD_LAT(2), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .start(start2), .src(src), .dst(dst), .count(count),
    .abort(abort), .gnt(gnt), .rd2(rd2_2), .req(req2), .a2(a2_2), .wd(wd_2),
    .we2(we2_2), .busy(busy2), .done(done2), .err(err2));

  always @(posedge clk) begin
    rd2_1 <= mem1.exists(a2_1) ? mem1[a2_1] : 32'h0;
    p2    <= mem2.exists(a2_2) ? mem2[a2_2] : 32'h0;
    rd2_2 <= p2;
    if (req1) reqc1++;
    if (we2_1) begin
      wa1.push_back(a2_1);
      wv1.push_back(wd_1);
    end
    if (we2_2) begin
      wa2.push_back(a2_2);
      wv2.push_back(wd_2);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Runs one u1 transfer; gm bit n drops gnt in cycle n, am bit n raises abort in cycle n.
  // n is the cycle in which done was seen (start sampled in cycle 0), e the err alongside it.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c,
                     input logic [63:0] gm, input logic [63:0] am, output int n, output logic e);
    src = s; dst = d; count = c; start = 1'b1; gnt = !gm[0]; abort = am[0]; n = 0;
    tick;
    start = 1'b0; n = 1; gnt = !gm[1]; abort = am[1];
    while (!done1 && n < 60) begin
      tick;
      n++;
      gnt = !gm[n]; abort = am[n];
    end
    e = err1;
    gnt = 1'b1; abort = 1'b0;
    tick;
  endtask

  initial begin
    int n, b, r;
    logic e;
    for (int i = 0; i < 4; i++) begin
      mem1[32'(i * 4)] = {8{4'(i + 1)}};
      mem2[32'(i * 4)] = {8{4'(i + 1)}};
    end
    #3;
    chk("rst_flags", {27'd0, req1, we2_1, busy1, done1, err1}, 32'h0);
    chk("rst_a2", a2_1, 32'h0);
    chk("rst_wd", wd_1, 32'h0);
    reset = 1'b1;
    tick;

    // normal copy
    b = wa1.size();
    run(32'h0, 32'h80, 16'd4, 64'h0, 64'h0, n, e);
    chk("t1_done_cycle", n, 14);
    chk("t1_err", {31'd0, e}, 32'h0);
    chk("t1_done_pulse", {31'd0, done1}, 32'h0);
    chk("t1_nwr", wa1.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wa1[b + i], 32'h80 + 32'(i * 4));
      chk("t1_data", wv1[b + i], {8{4'(i + 1)}});
    end

    // zero count and misalignment
    r = reqc1;
    run(32'h0, 32'h80, 16'd0, 64'h0, 64'h0, n, e);
    chk("t2_zero_cycle", n, 1);
    chk("t2_zero_err", {31'd0, e}, 32'h0);
    chk("t2_zero_noreq", reqc1 - r, 0);
    b = wa1.size();
    run(32'h2, 32'h80, 16'd1, 64'h0, 64'h0, n, e);
    chk("t2_mis_cycle", n, 1);
    chk("t2_mis_err", {31'd0, e}, 32'h1);
    chk("t2_mis_nwr", wa1.size() - b, 0);

    // MMIO guard
    b = wa1.size();
    run(32'h0, 32'hBFFF_FFFC, 16'd2, 64'h0, 64'h0, n, e);
    chk("t3_mmio_err", {31'd0, e}, 32'h1);
    chk("t3_mmio_cycle", n, 1);
    chk("t3_mmio_nwr", wa1.size() - b, 0);
    run(32'h0, 32'hBFFF_FFFC, 16'd1, 64'h0, 64'h0, n, e);
    chk("t3_ok_err", {31'd0, e}, 32'h0);
    chk("t3_ok_cycle", n, 5);
    chk("t3_ok_nwr", wa1.size() - b, 1);
    chk("t3_ok_addr", wa1[b], 32'hBFFF_FFFC);
    chk("t3_ok_data", wv1[b], 32'h1111_1111);

    // arbitration: gnt low in cycles 1-3 and 7-8 (WR of word 1 and the first HOLD)
    b = wa1.size();
    run(32'h0, 32'h100, 16'd4, 64'h18E, 64'h0, n, e);
    chk("t4_done_cycle", n, 19);
    chk("t4_err", {31'd0, e}, 32'h0);
    chk("t4_nwr", wa1.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_addr", wa1[b + i], 32'h100 + 32'(i * 4));
      chk("t4_data", wv1[b + i], {8{4'(i + 1)}});
    end

    // abort during WAIT of word 2 (cycle 6)
    b = wa1.size();
    run(32'h0, 32'h180, 16'd4, 64'h0, 64'h40, n, e);
    chk("t5_done_cycle", n, 8);
    chk("t5_err", {31'd0, e}, 32'h1);
    chk("t5_nwr", wa1.size() - b, 2);
    chk("t5_data2", wv1[b + 1], 32'h2222_2222);

    // asynchronous reset during WR of word 3, then RD_LAT=2 copy on u2
    src = 32'h0; dst = 32'h300; count = 16'd4; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("t6_wr3", {31'd0, we2_1}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_flags", {27'd0, req1, we2_1, busy1, done1, err1}, 32'h0);
    chk("t6_rst_a2", a2_1, 32'h0);
    chk("t6_rst_wd", wd_1, 32'h0);
    #2 reset = 1'b1;
    tick;
    b = wa2.size();
    src = 32'h0; dst = 32'h200; count = 16'd2; start2 = 1'b1;
    tick;
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 60) begin
      tick;
      n++;
    end
    chk("t6_done_cycle", n, 10);
    chk("t6_err", {31'd0, err2}, 32'h0);
    chk("t6_nwr", wa2.size() - b, 2);
    for (int i = 0; i < 2; i++) begin
      chk("t6_addr", wa2[b + i], 32'h200 + 32'(i * 4));
      chk("t6_data", wv2[b + i], {8{4'(i + 1)}});
    end
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
